axi_riscv_write_arb: RTL

AXI_RISCV_WRITE_ARB -- requirements
Module: axi_riscv_write_arb

---
 rtl/axi_riscv_arb_pkg.sv | 5 +
 rtl/fifo_v3.sv | 47 ++++
 rtl/axi_riscv_write_arb.sv | 76 +++++++
 3 files changed

// File: rtl/axi_riscv_arb_pkg.sv
// axi_riscv_arb_pkg: requester count and select type shared by the write arbiter.
package axi_riscv_arb_pkg;
  localparam int unsigned NumReq = 2;
  typedef logic sel_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO; a pop frees its slot for a push in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  logic [AddrDepth-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [AddrDepth:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  bypass, do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (AddrDepth+1)'(DEPTH);
    bypass  = FALL_THROUGH && empty_o && push_i;
    data_o  = bypass ? data_i : mem_q[rd_q];
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || pop_i) && !(bypass && pop_i);
    rd_d    = flush_i ? '0 : do_pop ? ((rd_q == AddrDepth'(DEPTH-1)) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d    = flush_i ? '0 : do_push ? ((wr_q == AddrDepth'(DEPTH-1)) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d   = flush_i ? '0 : cnt_q + (AddrDepth+1)'(do_push) - (AddrDepth+1)'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/axi_riscv_write_arb.sv
// axi_riscv_write_arb: round-robin AW arbiter for two requesters with W bursts
// forwarded in AW-grant order and B routed back by the returned ID MSB.
module axi_riscv_write_arb
  import axi_riscv_arb_pkg::*;
#(
  parameter int unsigned MaxWTxns = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] slv_aw_valid_i,
  output logic [NumReq-1:0] slv_aw_ready_o,
  input  logic [NumReq-1:0] slv_w_valid_i,
  input  logic [NumReq-1:0] slv_w_last_i,
  output logic [NumReq-1:0] slv_w_ready_o,
  output logic [NumReq-1:0] slv_b_valid_o,
  input  logic [NumReq-1:0] slv_b_ready_i,
  output logic              mst_aw_valid_o,
  input  logic              mst_aw_ready_i,
  output sel_t              mst_aw_sel_o,
  output logic              mst_w_valid_o,
  input  logic              mst_w_ready_i,
  output logic              mst_w_last_o,
  output sel_t              mst_w_sel_o,
  input  logic              mst_b_valid_i,
  input  sel_t              mst_b_sel_i,
  output logic              mst_b_ready_o
);
  sel_t ptr_q, ptr_d, lock_sel_q, lock_sel_d, aw_sel, w_head;
  logic lock_q, lock_d, fifo_full, fifo_empty, aw_block, aw_hs, w_act, w_pop;
  always_comb begin
    w_act          = rst_ni & ~fifo_empty;
    mst_w_sel_o    = w_act ? w_head : 1'b0;
    mst_w_valid_o  = w_act & slv_w_valid_i[w_head];
    mst_w_last_o   = w_act & slv_w_last_i[w_head];
    slv_w_ready_o  = (w_act & mst_w_ready_i) ? {w_head, ~w_head} : 2'b00;
    w_pop          = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
    // a locked grant holds until its handshake; otherwise a lone requester wins
    aw_sel         = lock_q ? lock_sel_q : (&slv_aw_valid_i) ? ptr_q : slv_aw_valid_i[1];
    aw_block       = fifo_full & ~w_pop;
    mst_aw_sel_o   = rst_ni & aw_sel;
    mst_aw_valid_o = rst_ni & slv_aw_valid_i[aw_sel] & ~aw_block;
    slv_aw_ready_o = (rst_ni & mst_aw_ready_i & ~aw_block) ? {aw_sel, ~aw_sel} : 2'b00;
    aw_hs          = mst_aw_valid_o & mst_aw_ready_i;
    ptr_d          = aw_hs ? ~aw_sel : ptr_q;
    lock_d         = mst_aw_valid_o & ~mst_aw_ready_i;
    lock_sel_d     = aw_sel;
    slv_b_valid_o  = (rst_ni & mst_b_valid_i) ? {mst_b_sel_i, ~mst_b_sel_i} : 2'b00;
    mst_b_ready_o  = rst_ni & slv_b_ready_i[mst_b_sel_i];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (1),
    .DEPTH        (MaxWTxns)
  ) i_w_order (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (aw_sel),
    .push_i  (aw_hs),
    .data_o  (w_head),
    .pop_i   (w_pop)
  );
endmodule
